// File: rtl/instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : instr_encoder
//  Purpose  : Encodes structured instruction requests into RV32I words and
//             writes them sequentially into instruction memory.
//             Optional NOP padding on flush: INSTR_ENCODER_NOP_PAD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module instr_encoder #(
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [12:0]       in_imm,
    input  logic              flush,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam logic [ADDR_W:0] c_depth     = (ADDR_W+1)'(DEPTH);
    localparam logic [6:0]      c_opc_imm   = 7'b0010011;
    localparam logic [6:0]      c_opc_reg   = 7'b0110011;
    localparam logic [6:0]      c_opc_store = 7'b0100011;
    localparam logic [6:0]      c_opc_br    = 7'b1100011;
    localparam logic [31:0]     c_nop       = 32'h0000_0013;

`ifdef INSTR_ENCODER_NOP_PAD_EN
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PAD  = 2'd1,
        S_DONE = 2'd2
    } state_t;
    localparam state_t c_flush_target = S_PAD;
`else
    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_DONE = 2'd2
    } state_t;
    localparam state_t c_flush_target = S_DONE;
`endif

    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [ADDR_W:0]     r_count;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic                r_flush_pend;

    logic                w_full;
    logic                w_accept;
    logic [2:0]          w_f3;
    logic [31:0]         w_word;
    logic [1:0]          w_err_code;

    assign w_full   = (r_count >= c_depth);
    assign w_accept = in_valid & in_ready;

    // Ops 0-3 and 4-7 share the same funct3 ordering (ADD/XOR/OR/AND)
    always_comb begin
        case (in_op[1:0])
            2'd0:    w_f3 = 3'b000;
            2'd1:    w_f3 = 3'b100;
            2'd2:    w_f3 = 3'b110;
            default: w_f3 = 3'b111;
        endcase
    end

    always_comb begin
        w_word     = '0;
        w_err_code = 2'd0;
        case (in_op)
            4'd0, 4'd1, 4'd2, 4'd3: begin
                w_word = {in_imm[11:0], in_rs1, w_f3, in_rd, c_opc_imm};
                if (in_imm[12] != in_imm[11]) w_err_code = 2'd2;
            end
            4'd4, 4'd5, 4'd6, 4'd7: begin
                w_word = {7'b0000000, in_rs2, in_rs1, w_f3, in_rd, c_opc_reg};
            end
            4'd8: begin
                w_word = {in_imm[11:5], in_rs2, in_rs1, 3'b010, in_imm[4:0], c_opc_store};
                if (in_imm[12] != in_imm[11]) w_err_code = 2'd2;
            end
            4'd9, 4'd10: begin
                w_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1,
                          2'b00, (in_op == 4'd9), in_imm[4:1], in_imm[11], c_opc_br};
                if (in_imm[1:0] != 2'b00) w_err_code = 2'd3;
            end
            default: w_err_code = 2'd1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_RUN;
        else     r_state <= w_state_nxt;
    end

    // A full memory takes priority over a pending flush
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        done        = 1'b0;
        case (r_state)
            S_RUN: begin
                in_ready = !w_full && !r_flush_pend;
                if (w_full)            w_state_nxt = S_DONE;
                else if (r_flush_pend) w_state_nxt = c_flush_target;
            end
`ifdef INSTR_ENCODER_NOP_PAD_EN
            S_PAD: begin
                if (w_full) w_state_nxt = S_DONE;
            end
`endif
            S_DONE: begin
                done = 1'b1;
                if (start) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_count      <= '0;
            r_err        <= 1'b0;
            r_err_code   <= 2'd0;
            r_flush_pend <= 1'b0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_RUN: begin
                    if (w_accept) begin
                        if (w_err_code == 2'd0) begin
                            r_we    <= 1'b1;
                            r_addr  <= r_count[ADDR_W-1:0];
                            r_wdata <= w_word;
                            r_count <= r_count + 1'b1;
                        end else begin
                            r_err <= 1'b1;
                            if (!r_err) r_err_code <= w_err_code;
                        end
                    end
                    // Flush waits one cycle so a word accepted alongside it still lands
                    if (flush && !w_full)         r_flush_pend <= 1'b1;
                    if (w_state_nxt != S_RUN)     r_flush_pend <= 1'b0;
                end
`ifdef INSTR_ENCODER_NOP_PAD_EN
                S_PAD: begin
                    if (!w_full) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_count[ADDR_W-1:0];
                        r_wdata <= c_nop;
                        r_count <= r_count + 1'b1;
                    end
                end
`endif
                S_DONE: begin
                    if (start) begin
                        r_count    <= '0;
                        r_err      <= 1'b0;
                        r_err_code <= 2'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign count      = r_count;
    assign err        = r_err;
    assign err_code   = r_err_code;

endmodule
`default_nettype wire

// File: tb/tb_instr_encoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_encoder
//  Purpose  : Self-checking bench for instr_encoder (DEPTH=256 and DEPTH=4).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [3:0]  op;
    logic [4:0]  rd, rs1, rs2;
    logic [12:0] imm;
    logic        va, vb, fa, sa, fb, sb;

    logic        rdy_a, we_a, done_a, err_a;
    logic [7:0]  addr_a;
    logic [31:0] wdata_a;
    logic [8:0]  cnt_a;
    logic [1:0]  ecode_a;

    logic        rdy_b, we_b, done_b, err_b;
    logic [1:0]  addr_b;
    logic [31:0] wdata_b;
    logic [2:0]  cnt_b;
    logic [1:0]  ecode_b;

    instr_encoder #(.ADDR_W(8), .DEPTH(256)) dut_a (
        .clk(clk), .rst(rst), .start(sa), .in_valid(va), .in_ready(rdy_a),
        .in_op(op), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
        .flush(fa), .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
        .count(cnt_a), .done(done_a), .err(err_a), .err_code(ecode_a)
    );

    instr_encoder #(.ADDR_W(2), .DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(sb), .in_valid(vb), .in_ready(rdy_b),
        .in_op(op), .in_rd(rd), .in_rs1(rs1), .in_rs2(rs2), .in_imm(imm),
        .flush(fb), .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
        .count(cnt_b), .done(done_b), .err(err_b), .err_code(ecode_b)
    );

    typedef struct {
        logic [3:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [12:0] imm;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cnt;
        int          cyc;
    } exp_t;

    vec_t vecs [13];
    exp_t q_a[$];
    exp_t q_b[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   mcnt_a = 0;
    int   mcnt_b = 0;
    int   exp_cnt_b;
    bit   acc;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic push(input bit b, input logic [31:0] w, input int c);
        exp_t e;
        e.data = w;
        e.cyc  = c;
        if (b) begin
            mcnt_b++;
            e.addr = mcnt_b - 1;
            e.cnt  = mcnt_b;
            q_b.push_back(e);
        end else begin
            mcnt_a++;
            e.addr = mcnt_a - 1;
            e.cnt  = mcnt_a;
            q_a.push_back(e);
        end
    endtask

    task automatic drive(input bit b, input logic [3:0] o, input logic [4:0] d,
                         input logic [4:0] s1, input logic [4:0] s2, input logic [12:0] im,
                         input logic [31:0] w, input bit legal, input bit fl, input bit st,
                         output bit accepted);
        @(negedge clk);
        op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
        va = !b; vb = b;
        fb = b & fl; sb = b & st;
        accepted = b ? rdy_b : rdy_a;
        if (accepted && legal) push(b, w, cyc + 1);
    endtask

    task automatic idle();
        @(negedge clk);
        va = 1'b0; vb = 1'b0; fb = 1'b0; sb = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && we_a) begin
            exp_t e;
            checks++;
            if (q_a.size() == 0) begin
                errors++;
                $display("FAIL write_a: unexpected write addr=%0d data=%h", addr_a, wdata_a);
            end else begin
                e = q_a.pop_front();
                if (int'(addr_a) != e.addr || wdata_a !== e.data || int'(cnt_a) != e.cnt ||
                    (e.cyc != 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL write_a: got addr=%0d data=%h count=%0d cyc=%0d expected addr=%0d data=%h count=%0d cyc=%0d",
                             addr_a, wdata_a, cnt_a, cyc, e.addr, e.data, e.cnt, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && we_b) begin
            exp_t e;
            checks++;
            if (q_b.size() == 0) begin
                errors++;
                $display("FAIL write_b: unexpected write addr=%0d data=%h", addr_b, wdata_b);
            end else begin
                e = q_b.pop_front();
                if (int'(addr_b) != e.addr || wdata_b !== e.data || int'(cnt_b) != e.cnt ||
                    (e.cyc != 0 && cyc != e.cyc)) begin
                    errors++;
                    $display("FAIL write_b: got addr=%0d data=%h count=%0d cyc=%0d expected addr=%0d data=%h count=%0d cyc=%0d",
                             addr_b, wdata_b, cnt_b, cyc, e.addr, e.data, e.cnt, e.cyc);
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        va = 1'b0; vb = 1'b0; fa = 1'b0; sa = 1'b0; fb = 1'b0; sb = 1'b0;
        op = '0; rd = '0; rs1 = '0; rs2 = '0; imm = '0;

        vecs[0]  = '{4'd0,  5'd1,  5'd0,  5'd0,  13'd5,     32'h00500093};
        vecs[1]  = '{4'd4,  5'd3,  5'd1,  5'd2,  13'h0FFF,  32'h002081B3};
        vecs[2]  = '{4'd8,  5'd31, 5'd1,  5'd2,  13'd8,     32'h0020A423};
        vecs[3]  = '{4'd9,  5'd0,  5'd1,  5'd2,  13'h1FF8,  32'hFE209CE3};
        vecs[4]  = '{4'd1,  5'd5,  5'd6,  5'd0,  13'h1FFF,  32'hFFF34293};
        vecs[5]  = '{4'd2,  5'd10, 5'd11, 5'd0,  13'd2047,  32'h7FF5E513};
        vecs[6]  = '{4'd3,  5'd31, 5'd31, 5'd0,  13'h1800,  32'h800FFF93};
        vecs[7]  = '{4'd5,  5'd4,  5'd5,  5'd6,  13'd0,     32'h0062C233};
        vecs[8]  = '{4'd6,  5'd7,  5'd8,  5'd9,  13'd0,     32'h009463B3};
        vecs[9]  = '{4'd7,  5'd1,  5'd2,  5'd3,  13'd0,     32'h003170B3};
        vecs[10] = '{4'd10, 5'd0,  5'd3,  5'd4,  13'd16,    32'h00418863};
        vecs[11] = '{4'd8,  5'd0,  5'd2,  5'd31, 13'h1FFC,  32'hFFF12E23};
        vecs[12] = '{4'd9,  5'd0,  5'd0,  5'd0,  13'h1000,  32'h80001063};

        repeat (2) @(negedge clk);
        chk("reset_ready_a", rdy_a, 1);
        chk("reset_we_a", we_a, 0);
        chk("reset_addr_a", addr_a, 0);
        chk("reset_wdata_a", wdata_a, 0);
        chk("reset_count_a", cnt_a, 0);
        chk("reset_done_a", done_a, 0);
        chk("reset_err_a", err_a, 0);
        chk("reset_errcode_a", ecode_a, 0);
        chk("reset_ready_b", rdy_b, 1);
        chk("reset_count_b", cnt_b, 0);
        @(negedge clk);
        rst = 1'b0;

        // Encoding table, back to back
        for (int i = 0; i < 13; i++) begin
            drive(0, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                  vecs[i].word, 1, 0, 0, acc);
            chk("table_accept", acc, 1);
        end
        idle();
        repeat (3) @(negedge clk);
        chk("table_drained", q_a.size(), 0);
        chk("table_count", cnt_a, 13);

        // Misaligned branch
        drive(0, 4'd10, 5'd0, 5'd1, 5'd2, 13'd6, 32'h0, 0, 0, 0, acc);
        chk("beq_mis_accept", acc, 1);
        idle();
        chk("beq_mis_err", err_a, 1);
        chk("beq_mis_code", ecode_a, 3);
        chk("beq_mis_count", cnt_a, 13);

        // Async reset with a write in flight
        drive(0, 4'd0, 5'd1, 5'd0, 5'd0, 13'd5, 32'h00500093, 1, 0, 0, acc);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_we", we_a, 0);
        chk("rst_mid_count", cnt_a, 0);
        chk("rst_mid_err", err_a, 0);
        q_a.delete(); q_b.delete();
        mcnt_a = 0; mcnt_b = 0;
        va = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        // Illegal op then out-of-range immediate: first error wins
        drive(0, 4'd12, 5'd1, 5'd0, 5'd0, 13'd0, 32'h0, 0, 0, 0, acc);
        chk("illegal_accept", acc, 1);
        drive(0, 4'd0, 5'd1, 5'd0, 5'd0, 13'd2048, 32'h0, 0, 0, 0, acc);
        chk("imm_range_accept", acc, 1);
        idle();
        chk("first_err", err_a, 1);
        chk("first_err_code", ecode_a, 1);
        chk("err_count", cnt_a, 0);
        drive(0, vecs[0].op, vecs[0].rd, vecs[0].rs1, vecs[0].rs2, vecs[0].imm,
              vecs[0].word, 1, 0, 0, acc);
        idle();
        repeat (2) @(negedge clk);
        chk("post_err_drained", q_a.size(), 0);

        // DEPTH=4: illegal op (with a start that RUN must ignore), then 5 requests
        drive(1, 4'd13, 5'd0, 5'd0, 5'd0, 13'd0, 32'h0, 0, 0, 1, acc);
        for (int i = 0; i < 5; i++) begin
            drive(1, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm,
                  vecs[i].word, 1, 0, 0, acc);
            chk("full_accept", acc, (i < 4) ? 1 : 0);
        end
        idle();
        repeat (2) @(negedge clk);
        chk("full_done", done_b, 1);
        chk("full_ready", rdy_b, 0);
        chk("full_count", cnt_b, 4);
        chk("full_err", err_b, 1);
        chk("full_drained", q_b.size(), 0);
        drive(1, 4'd0, 5'd0, 5'd0, 5'd0, 13'd0, 32'h0, 0, 1, 0, acc);
        idle();
        chk("flush_in_done", done_b, 1);
        sb = 1'b1;
        @(negedge clk);
        sb = 1'b0;
        mcnt_b = 0;
        chk("start_done", done_b, 0);
        chk("start_count", cnt_b, 0);
        chk("start_err", err_b, 0);
        chk("start_errcode", ecode_b, 0);
        chk("start_ready", rdy_b, 1);

        // Two requests, flush alongside the second
        drive(1, vecs[5].op, vecs[5].rd, vecs[5].rs1, vecs[5].rs2, vecs[5].imm,
              vecs[5].word, 1, 0, 0, acc);
        chk("flush_seq_accept0", acc, 1);
        drive(1, vecs[6].op, vecs[6].rd, vecs[6].rs1, vecs[6].rs2, vecs[6].imm,
              vecs[6].word, 1, 1, 0, acc);
        chk("flush_seq_accept1", acc, 1);
`ifdef INSTR_ENCODER_NOP_PAD_EN
        push(1, 32'h00000013, 0);
        push(1, 32'h00000013, 0);
        exp_cnt_b = 4;
`else
        exp_cnt_b = 2;
`endif
        idle();
        repeat (6) @(negedge clk);
        chk("flush_done", done_b, 1);
        chk("flush_count", cnt_b, exp_cnt_b);
        chk("flush_drained", q_b.size(), 0);
        chk("final_drained_a", q_a.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
